// File: rtl/shift_seq_if.sv
// shift_seq_if -- bundles the request/response signals and the downstream
// shifter bus of shift_seq into one interface.
//
// Parameter:
//   W        data width (>= 8)
//
// Signals:
//   start    request strobe (sampled only while the sequencer is idle)
//   op       operation code: 000 pass, 001 rotl, 010 rotr, 011 LSL, 100 ASR, 101 LSR
//   data_in  operand
//   amount   total shift/rotate count (0..31)
//   busy     high while the sequencer is not idle
//   done     one-cycle completion pulse
//   result   final value, held until the next completion
//   sh_code  shift code to the downstream shifter
//   sh_a     shifter operand
//   sh_b     shifter amount for the current pass
//   sh_out   combinational shifter result
//
// Modports:
//   slave    the sequencer (shift_seq)
//   master   the requester side, which also hosts the downstream shifter
interface shift_seq_if #(
  parameter int W = 8
);
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] data_in;
  logic [4:0]   amount;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [2:0]   sh_code;
  logic [W-1:0] sh_a;
  logic [2:0]   sh_b;
  logic [W-1:0] sh_out;

  modport slave (
    input  start, op, data_in, amount, sh_out,
    output busy, done, result, sh_code, sh_a, sh_b
  );

  modport master (
    output start, op, data_in, amount, sh_out,
    input  busy, done, result, sh_code, sh_a, sh_b
  );
endinterface

// File: rtl/shift_seq.sv
// shift_seq -- multi-pass shift/rotate sequencer. Breaks a shift or rotate of
// up to 31 positions into passes through an external shifter that can only
// move 0..7 positions per pass (rotates go 1 position per pass).
//
// Parameter:
//   W        data width (>= 8)
//
// Ports:
//   clk      single clock, rising edge
//   reset    asynchronous active-high reset
//   bus      shift_seq_if.slave (request, response and shifter signals)
//
// Optional feature:
//   SHIFT_SEQ_SAT_EN  when defined, LSL/LSR/ASR with amount >= W finish
//                     without any shifter pass (saturated value loaded at
//                     start); when undefined they iterate like any other shift.
//
// States:
//   state  | meaning
//   IDLE   | waiting for start, shifter bus parked
//   RUN    | one shifter pass per cycle until the remaining count is 0
//   DONE   | completion pulse, result valid; always back to IDLE next cycle
module shift_seq #(
  parameter int W = 8
) (
  input logic        clk,
  input logic        reset,
  shift_seq_if.slave bus
);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ROTL = 3'b001;
  localparam logic [2:0] OP_ROTR = 3'b010;
  localparam logic [2:0] OP_LSL  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_LSR  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [2:0]   op_q;
  logic [W-1:0] acc;
  logic [4:0]   rem;
  logic [W-1:0] result_q;

  // Start-side decode
  logic [2:0]   op_norm;
  logic         is_rot_in;
  logic         is_shift_in;
  logic         sat_hit;
  logic         zero_pass;
  logic [W-1:0] load_val;
  logic [4:0]   load_rem;

  // Run-side decode
  logic         is_rot_q;
  logic [2:0]   step;
  logic [4:0]   rem_next;

  // Reserved codes behave as pass.
  always_comb begin
    op_norm = bus.op;
    if (bus.op > OP_LSR) begin
      op_norm = OP_PASS;
    end
  end

  assign is_rot_in   = (op_norm == OP_ROTL) || (op_norm == OP_ROTR);
  assign is_shift_in = (op_norm == OP_LSL) || (op_norm == OP_ASR) || (op_norm == OP_LSR);

`ifdef SHIFT_SEQ_SAT_EN
  logic [31:0]  amount_ext;
  logic [W-1:0] sat_val;

  assign amount_ext = {27'd0, bus.amount};
  assign sat_hit    = is_shift_in && (amount_ext >= 32'(W));
  // ASR saturates to the sign fill, logical shifts to zero.
  assign sat_val    = (op_norm == OP_ASR) ? {W{bus.data_in[W-1]}} : '0;
  assign load_val   = sat_hit ? sat_val : bus.data_in;
`else
  assign sat_hit    = 1'b0;
  assign load_val   = bus.data_in;
`endif

  assign zero_pass = (op_norm == OP_PASS) || (bus.amount == 5'd0) || sat_hit ||
                     !(is_rot_in || is_shift_in);
  assign load_rem  = sat_hit ? 5'd0 : bus.amount;

  assign is_rot_q  = (op_q == OP_ROTL) || (op_q == OP_ROTR);

  // Rotates advance one position per pass; shifts take up to 7 at a time.
  always_comb begin
    step = 3'd1;
    if (!is_rot_q) begin
      step = (rem > 5'd7) ? 3'd7 : rem[2:0];
    end
  end

  assign rem_next = rem - {2'b00, step};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = zero_pass ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (rem_next == 5'd0) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath. result is written only on the edge that enters DONE, so a
  // reset mid-operation leaves it at zero and start while busy cannot touch it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= OP_PASS;
      acc      <= '0;
      rem      <= 5'd0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q <= op_norm;
            acc  <= load_val;
            rem  <= load_rem;
            if (zero_pass) begin
              result_q <= load_val;
            end
          end
        end
        S_RUN: begin
          acc <= bus.sh_out;
          rem <= rem_next;
          if (rem_next == 5'd0) begin
            result_q <= bus.sh_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Shifter bus is parked (code 000, amount 0) outside RUN.
  always_comb begin
    bus.sh_code = OP_PASS;
    bus.sh_b    = 3'd0;
    bus.sh_a    = acc;
    if (state == S_RUN) begin
      bus.sh_code = op_q;
      bus.sh_b    = step;
    end
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = (state == S_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_shift_seq.sv
module tb_shift_seq;
  localparam int WT = 8;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;
  logic [WT-1:0] prev_result;

  shift_seq_if #(.W(WT)) bus ();

  shift_seq #(.W(WT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Downstream 3-bit-amount shifter.
  function automatic logic [WT-1:0] shifter(input logic [2:0] c, input logic [WT-1:0] a,
                                            input logic [2:0] b);
    logic signed [WT-1:0] sa;
    sa = a;
    case (c)
      3'b001:  return {a[WT-2:0], a[WT-1]};
      3'b010:  return {a[0], a[WT-1:1]};
      3'b011:  return a << b;
      3'b100:  return sa >>> b;
      3'b101:  return a >> b;
      default: return a;
    endcase
  endfunction

  assign bus.sh_out = shifter(bus.sh_code, bus.sh_a, bus.sh_b);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Whole-operation reference: the value after moving amt positions in one go.
  function automatic logic [WT-1:0] ref_result(input logic [2:0] op, input logic [WT-1:0] d,
                                               input int amt);
    logic signed [WT-1:0] sd;
    logic [WT-1:0] r;
    int k;
    sd = d;
    case (op)
      3'b001: begin
        k = amt % WT;
        r = (k == 0) ? d : ((d << k) | (d >> (WT - k)));
      end
      3'b010: begin
        k = amt % WT;
        r = (k == 0) ? d : ((d >> k) | (d << (WT - k)));
      end
      3'b011:  r = (amt >= WT) ? '0 : (d << amt);
      3'b100:  r = sd >>> amt;
      3'b101:  r = (amt >= WT) ? '0 : (d >> amt);
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic int ref_passes(input logic [2:0] op, input int amt);
    int n;
    n = 0;
    case (op)
      3'b001, 3'b010: n = amt;
      3'b011, 3'b100, 3'b101: begin
        n = (amt + 6) / 7;
`ifdef SHIFT_SEQ_SAT_EN
        if (amt >= WT) n = 0;
`endif
      end
      default: n = 0;
    endcase
    if (amt == 0) n = 0;
    return n;
  endfunction

  task automatic scramble_inputs();
    bus.op      = 3'($urandom_range(0, 7));
    bus.data_in = WT'($urandom);
    bus.amount  = 5'($urandom_range(0, 31));
  endtask

  task automatic run_op(input logic [2:0] op, input logic [WT-1:0] d, input logic [4:0] amt,
                        input bit poke);
    logic [2:0]    eop;
    logic [WT-1:0] exp_res;
    int n, consumed, step, cyc;
    bit seen;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.done, 0);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.data_in = d;
    bus.amount  = amt;
    eop      = (op > 3'b101) ? 3'b000 : op;
    n        = ref_passes(eop, int'(amt));
    exp_res  = ref_result(eop, d, int'(amt));
    consumed = 0;
    seen     = 0;
    cyc      = 1;
    while (cyc <= 40 && !seen) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        chk("done_cycle", cyc, n + 1);
        chk("result", bus.result, exp_res);
        chk("done_busy", bus.busy, 1);
        bus.start   = 1'b0;
        prev_result = exp_res;
      end else begin
        chk("run_busy", bus.busy, 1);
        chk("run_code", bus.sh_code, eop);
        if (eop == 3'b001 || eop == 3'b010) step = 1;
        else step = (int'(amt) - consumed > 7) ? 7 : int'(amt) - consumed;
        chk("run_shb", bus.sh_b, step);
        chk("run_sha", bus.sh_a, ref_result(eop, d, consumed));
        chk("run_hold", bus.result, prev_result);
        consumed += step;
        scramble_inputs();
        bus.start = 1'($urandom_range(0, 1));
        if (poke && cyc == 1) bus.start = 1'b1;
      end
      cyc++;
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
      bus.start = 1'b0;
    end
  endtask

  initial begin
    n_chk       = 0;
    n_err       = 0;
    prev_result = '0;
    clk         = 1'b0;
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.op      = 3'b000;
    bus.data_in = '0;
    bus.amount  = 5'd0;
    #1 reset = 1'b1;
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_code", bus.sh_code, 0);
    chk("rst_shb", bus.sh_b, 0);
    chk("rst_sha", bus.sh_a, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    run_op(3'b011, 8'h01, 5'd3, 0);
    chk("lsl3", bus.result, 8'h08);
    run_op(3'b101, 8'h80, 5'd10, 0);
    run_op(3'b100, 8'h80, 5'd9, 0);
    chk("asr9", bus.result, 8'hFF);
    run_op(3'b010, 8'h01, 5'd3, 0);
    chk("rotr3", bus.result, 8'h20);
    run_op(3'b000, 8'h5A, 5'd13, 0);
    run_op(3'b011, 8'h5A, 5'd0, 0);
    run_op(3'b110, 8'h5A, 5'd5, 0);
    run_op(3'b111, 8'hC3, 5'd9, 0);
    run_op(3'b001, 8'hA5, 5'd31, 0);
    run_op(3'b100, 8'h7F, 5'd31, 0);
    run_op(3'b010, 8'h01, 5'd3, 1);

    // Reset in the middle of a long LSR.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = 3'b101;
    bus.data_in = 8'hF0;
    bus.amount  = 5'd20;
    @(negedge clk);
    bus.start = 1'b0;
    chk("pre_rst_busy", bus.busy, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_code", bus.sh_code, 0);
    chk("abort_shb", bus.sh_b, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    prev_result = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_nodone", bus.done, 0);
      chk("abort_hold", bus.result, 0);
    end
    run_op(3'b101, 8'hF0, 5'd20, 0);

    for (int i = 0; i < 30; i++) begin
      run_op(3'($urandom_range(0, 7)), WT'($urandom), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 SHALL have parameter W, default 8, data width (W >= 8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request strobe, sampled only in IDLE.
REQ-005 SHALL have port op, input, 3, operation: 000 pass, 001 rotate-left, 010 rotate-right, 011 LSL, 100 ASR, 101 LSR.
REQ-006 SHALL have port data_in, input, W, operand.
REQ-007 SHALL have port amount, input, 5, total shift/rotate count (0..31).
REQ-008 SHALL have port sh_code, output, 3, shift code driven to the downstream 3-bit-amount shifter.
REQ-009 SHALL have port sh_a, output, W, shifter operand.
REQ-010 SHALL have port sh_b, output, 3, shifter amount for this pass.
REQ-011 SHALL have port sh_out, input, W, combinational shifter result for the current sh_code/sh_a/sh_b.
REQ-012 SHALL have ports busy (output, 1, high outside IDLE), done (output, 1, one-cycle completion pulse) and result (output, W, final value).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 In IDLE with start=1, SHALL latch op, data_in into acc, amount into rem; codes 110/111 SHALL be latched as 000.
REQ-015 Next state after start SHALL be DONE when pass count N=0, else RUN.
REQ-016 N SHALL be 0 for op 000 or amount 0; amount for rotates (1 position per pass); ceil(amount/7) for LSL/ASR/LSR.
REQ-017 In RUN, SHALL drive sh_code=op, sh_a=acc, sh_b=step; step=min(rem,7) for shifts, 1 for rotates (sh_b ignored by shifter for rotates).
REQ-018 Each RUN cycle SHALL register acc<=sh_out and rem<=rem-step; SHALL move to DONE when the new rem is 0.
REQ-019 In IDLE and DONE, SHALL drive sh_code=000, sh_a=acc, sh_b=0.
REQ-020 On entry to DONE, result SHALL load acc; result SHALL hold until the next completion.
REQ-021 done SHALL be high exactly one cycle (DONE state); DONE SHALL always return to IDLE next cycle.
REQ-022 Latency: start sampled in cycle 0 SHALL yield done in cycle N+1; new start accepted in cycle N+2.
REQ-023 start while busy=1 SHALL be ignored with no effect on state, acc, rem or result.
REQ-024 Inputs op/data_in/amount SHALL be don't-care outside the start-accept cycle.

Reset
REQ-025 reset SHALL asynchronously force IDLE, acc=0, rem=0, result=0, done=0, busy=0, sh_code=000, sh_b=0.
REQ-026 reset asserted mid-RUN SHALL abort the operation with no done pulse and result=0.
REQ-027 After reset deassertion, start SHALL be accepted on the first rising edge.

Configuration
REQ-028 Macro SHIFT_SEQ_SAT_EN SHALL select the saturation shortcut.
REQ-029 With SHIFT_SEQ_SAT_EN defined, LSL/LSR with amount>=W SHALL load acc=0, and ASR with amount>=W SHALL load acc=all copies of data_in[W-1], with N=0 (done in cycle 1).
REQ-030 Without SHIFT_SEQ_SAT_EN, such cases SHALL iterate per REQ-016; final result SHALL be identical, only latency differs.

Verification
REQ-031 W=8, op=011, data_in=0x01, amount=3 -> one pass sh_b=3, result=0x08, done in cycle 2.
REQ-032 op=101, data_in=0x80, amount=10 -> passes sh_b=7 then 3, result=0x00, done in cycle 3 (cycle 1 with SHIFT_SEQ_SAT_EN).
REQ-033 op=100, data_in=0x80, amount=9 -> result=0xFF; op=010, data_in=0x01, amount=3 -> three passes, result=0x20, done in cycle 4.
REQ-034 op=000 or amount=0 with data_in=0x5A -> no RUN cycle, result=0x5A, done in cycle 1.
REQ-035 start pulsed in cycle 1 of a 3-pass operation -> ignored, one done pulse, result of the first request only.
REQ-036 reset asserted during RUN of LSR amount=20 -> immediate IDLE, result=0, no done; a following start completes normally.
